// File: rtl/immediate_extender_stream_if.sv
// Valid/ready stream bundle for the immediate extender: request side in,
// extended-immediate side out, plus occupancy.
interface immediate_extender_stream_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [24:0]      instruction;
    logic [2:0]       immediate_source;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, instruction, immediate_source, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag, out_err, count
    );

    modport slave (
        input  in_valid, instruction, immediate_source, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag, out_err, count
    );
endinterface

// File: rtl/immediate_extender_stream.sv
// Buffered RV immediate generator: extends on push, queues results in a
// DEPTH-entry FIFO, presents the head over valid/ready.
module immediate_extender_stream #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input logic clk,
    input logic rst,
    immediate_extender_stream_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [31:7]     w_ins;
    logic [31:0]     w_imm;
    logic            w_sx;
    logic            w_err;
    logic [XLEN-1:0] w_ext;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    assign w_ins = bus.instruction;

    always_comb begin
        w_imm = '0;
        w_sx  = 1'b0;
        w_err = 1'b0;
        unique case (bus.immediate_source)
            3'b000: begin
                w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
                w_sx  = 1'b1;
            end
            3'b001: begin
                w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
                w_sx  = 1'b1;
            end
            3'b010: begin
                w_imm = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25],
                         w_ins[11:8], 1'b0};
                w_sx  = 1'b1;
            end
            3'b011: begin
                w_imm = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20],
                         w_ins[30:21], 1'b0};
                w_sx  = 1'b1;
            end
            3'b100: begin
                w_imm = {w_ins[31:12], 12'b0};
                w_sx  = 1'b1;
            end
            3'b101: w_imm = {27'b0, w_ins[19:15]};
            3'b110: begin
                if (XLEN == 64) w_imm = {26'b0, w_ins[25:20]};
                else            w_imm = {27'b0, w_ins[24:20]};
            end
            default: w_err = 1'b1;
        endcase
    end

    // 33-bit signed view: top bit only set for sign-extending formats
    assign w_ext = XLEN'($signed({w_sx & w_imm[31], w_imm}));

    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = bus.in_valid && !w_full;
    assign w_pop  = bus.out_ready && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{err: w_err, tag: bus.in_tag, val: w_ext};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = (r_count != '0);
    assign bus.out       = r_mem[r_rd_ptr].val;
    assign bus.out_tag   = r_mem[r_rd_ptr].tag;
    assign bus.out_err   = r_mem[r_rd_ptr].err;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_immediate_extender_stream.sv
// Drives XLEN=32 and XLEN=64 instances with identical streams and checks
// both against a queue-based reference model.
module tb_immediate_extender_stream;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             vin  = 1'b0;
    logic             ordy = 1'b0;
    logic [31:0]      ins  = '0;
    logic [2:0]       src  = '0;
    logic [TAG_W-1:0] tg   = '0;

    immediate_extender_stream_if #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) b32 ();
    immediate_extender_stream_if #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) b64 ();

    immediate_extender_stream #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u32 (
        .clk(clk), .rst(rst), .bus(b32.slave));
    immediate_extender_stream #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u64 (
        .clk(clk), .rst(rst), .bus(b64.slave));

    assign b32.in_valid = vin;
    assign b32.instruction = ins[31:7];
    assign b32.immediate_source = src;
    assign b32.in_tag = tg;
    assign b32.out_ready = ordy;
    assign b64.in_valid = vin;
    assign b64.instruction = ins[31:7];
    assign b64.immediate_source = src;
    assign b64.in_tag = tg;
    assign b64.out_ready = ordy;

    typedef struct {
        logic [63:0]      v32;
        logic [63:0]      v64;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    bit   fresh;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] s, input int xlen);
        longint v;
        case (s)
            3'd0: v = longint'($signed(i[31:20]));
            3'd1: v = longint'($signed({i[31:25], i[11:7]}));
            3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
            3'd3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
            3'd4: v = longint'($signed(i[31:12])) * 4096;
            3'd5: v = longint'(i[19:15]);
            3'd6: v = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count32", 64'(b32.count), 64'(n));
        chk("count64", 64'(b64.count), 64'(n));
        chk("in_ready32", 64'(b32.in_ready), 64'(n != DEPTH));
        chk("in_ready64", 64'(b64.in_ready), 64'(n != DEPTH));
        chk("out_valid32", 64'(b32.out_valid), 64'(n != 0));
        chk("out_valid64", 64'(b64.out_valid), 64'(n != 0));
        if (n != 0) begin
            chk("out32", 64'(b32.out), q[0].v32);
            chk("out64", b64.out, q[0].v64);
            chk("tag32", 64'(b32.out_tag), 64'(q[0].tag));
            chk("tag64", 64'(b64.out_tag), 64'(q[0].tag));
            chk("err32", 64'(b32.out_err), 64'(q[0].err));
            chk("err64", 64'(b64.out_err), 64'(q[0].err));
        end else if (fresh) begin
            chk("rst_out32", 64'(b32.out), 64'd0);
            chk("rst_out64", b64.out, 64'd0);
            chk("rst_tag", 64'(b32.out_tag), 64'd0);
            chk("rst_err", 64'(b64.out_err), 64'd0);
        end
    endtask

    task automatic cyc(output bit took);
        exp_t e;
        bit   pop;
        took = vin && (q.size() < DEPTH);
        pop  = ordy && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (took) begin
            e.v32 = ref_imm(ins, src, 32);
            e.v64 = ref_imm(ins, src, 64);
            e.err = (src == 3'd7);
            e.tag = tg;
            q.push_back(e);
            fresh = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic tick();
        bit t;
        cyc(t);
    endtask

    task automatic push1(input logic [2:0] s, input logic [31:0] i,
                         input logic [TAG_W-1:0] t);
        vin = 1'b1; src = s; ins = i; tg = t;
        tick();
        vin = 1'b0;
    endtask

    task automatic drain();
        ordy = 1'b1;
        for (int k = 0; k < 3 * DEPTH && q.size() != 0; k++) tick();
        chk("drained", 64'(b32.count), 64'd0);
        ordy = 1'b0;
    endtask

    initial begin
        bit took;
        fresh = 1'b1;
        #1 rst = 1'b1;
        #2 check_all();
        #5 rst = 1'b0;
        tick();

        // 1: I-type, no flow-through before the edge
        vin = 1'b1; src = 3'd0; ins = 32'hFFF00093; tg = 5'd3;
        #1 chk("no_flow", 64'(b32.out_valid), 64'd0);
        tick();
        vin = 1'b0;
        chk("t1_out", 64'(b32.out), 64'hFFFF_FFFF);
        drain();

        // 2: B then J
        push1(3'd2, 32'hFE000EE3, 5'd1);
        chk("t2_b", 64'(b32.out), 64'hFFFF_FFFC);
        push1(3'd3, 32'h0080006F, 5'd2);
        drain();

        // 3: U and SH on XLEN=64
        push1(3'd4, 32'h800000B7, 5'd4);
        chk("t3_u64", b64.out, 64'hFFFF_FFFF_8000_0000);
        ordy = 1'b1;
        push1(3'd6, 32'h03F09093, 5'd5);
        chk("t3_sh64", b64.out, 64'h3F);
        drain();

        // 4: Z, illegal, then legal
        push1(3'd5, 32'h000F8000, 5'd6);
        chk("t4_z", 64'(b32.out), 64'h1F);
        push1(3'd7, $urandom, 5'd7);
        push1(3'd1, $urandom, 5'd8);
        drain();

        // 5: overfill with out_ready low, then drain holding tag 5
        vin = 1'b1; src = 3'd0;
        for (int t = 1; t <= 5; t++) begin
            tg = TAG_W'(t); ins = $urandom;
            if (t < 5) tick();
        end
        tick();
        chk("t5_full", 64'(b32.in_ready), 64'd0);
        ordy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(took);
            if (took) break;
        end
        vin = 1'b0;
        drain();

        // 6: async reset mid-stream with three entries queued
        for (int t = 0; t < 3; t++) push1(3'(t), $urandom, TAG_W'(t + 9));
        #2 rst = 1'b1;
        #1;
        q.delete();
        fresh = 1'b1;
        check_all();
        #2 rst = 1'b0;
        vin = 1'b1; src = 3'd0; ins = 32'h7FF00013; tg = 5'd20;
        tick();
        vin = 1'b0;
        chk("t6_new", 64'(b32.out), 64'h7FF);
        drain();

        // random traffic
        for (int k = 0; k < 300; k++) begin
            vin  = 1'($urandom);
            ordy = 1'($urandom);
            src  = 3'($urandom);
            ins  = $urandom;
            tg   = TAG_W'($urandom);
            tick();
        end
        vin = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
